// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and reset defaults for the serial pattern detector
//
// Purpose: controller state encoding, stream byte width and the reset-time pattern
//          configuration (1011, length 4).
// Ports:   none (package).
package seq_det_pkg;

    localparam int         BYTE_W      = 8;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;
    localparam int         DEF_LEN     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SHIFT = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - bit history, fill count, masked compare and registered det
//
// Purpose: shifts one bit per bit_vld into a history register (newest bit in LSB),
//          tracks how many valid bits it holds, and flags a match when the low len
//          bits equal the low len bits of the pattern.
// Macro:   SEQ_DET_NONOVERLAP_EN - history and fill restart on every match.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bit_in     serial bit
//   bit_vld    bit_in enters history at this edge
//   clr_hist   empties history and fill count
//   pattern    pattern to match, newest bit in LSB
//   len        pattern length (0 -> 1, clamped to PAT_W)
//   hit        combinational: the most recent bit completed a match
//   det        hit registered (one-cycle pulse)
module pattern_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bit_in,
    input  logic                       bit_vld,
    input  logic                       clr_hist,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [$clog2(PAT_W+1)-1:0] len,
    output logic                       hit,
    output logic                       det
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_base;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_base;
    logic [LEN_W-1:0] len_eff;
    // Set only on the cycle after a new bit arrived, so a match sitting in
    // history during an idle gap is not reported again.
    logic             hist_new;

    always_comb begin
        if (len == '0) begin
            len_eff = LEN_W'(1);
        end else if (len > LEN_W'(PAT_W)) begin
            len_eff = LEN_W'(PAT_W);
        end else begin
            len_eff = len;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_eff);
        end
    end

    assign hit = hist_new && (fill >= len_eff) && (((hist ^ pattern) & mask) == '0);

    // The bit following a match is already being shifted in on the edge where
    // the match is consumed, so in non-overlapping mode it lands in an empty history.
    always_comb begin
`ifdef SEQ_DET_NONOVERLAP_EN
        hist_base = hit ? '0 : hist;
        fill_base = hit ? '0 : fill;
`else
        hist_base = hist;
        fill_base = fill;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist     <= '0;
            fill     <= '0;
            hist_new <= 1'b0;
            det      <= 1'b0;
        end else begin
            det <= hit;
            if (clr_hist) begin
                hist     <= '0;
                fill     <= '0;
                hist_new <= 1'b0;
            end else begin
                hist_new <= bit_vld;
                if (bit_vld) begin
                    hist <= {hist_base[PAT_W-2:0], bit_in};
                    fill <= (fill_base == LEN_W'(PAT_W)) ? fill_base : fill_base + LEN_W'(1);
                end else begin
                    hist <= hist_base;
                    fill <= fill_base;
                end
            end
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// rtl/seq_det_stream_ctrl.sv - byte-stream front end, FSM and counter for the pattern detector
//
// Purpose: accepts bytes over valid/ready, shifts each MSB first into pattern_match_core,
//          counts detections (saturating) and halts with a sticky irq at the threshold.
// Macro:   SEQ_DET_NONOVERLAP_EN (passed through to pattern_match_core).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            1 = run, 0 = abort to IDLE (history cleared, count kept)
//   cfg_we        config write, honoured only in IDLE
//   cfg_pattern   pattern, newest bit in LSB
//   cfg_len       pattern length, 0 treated as 1
//   cfg_thresh    irq threshold, 0 = never halt
//   clr           clears det_cnt/irq; leaves HALT
//   in_valid      byte available
//   in_data       byte, shifted MSB first
//   in_ready      byte accepted when in_valid & in_ready
//   det           one-cycle detection pulse
//   det_cnt       saturating detection count
//   irq           sticky threshold interrupt
//   busy          byte being shifted
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cfg_we,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic [CNT_W-1:0]           cfg_thresh,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       det,
    output logic [CNT_W-1:0]           det_cnt,
    output logic                       irq,
    output logic                       busy
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int IDX_W = $clog2(BYTE_W);

    state_t              state;
    logic [BYTE_W-1:0]   shreg;
    logic [IDX_W-1:0]    bit_idx;
    logic [PAT_W-1:0]    pattern_r;
    logic [LEN_W-1:0]    len_r;
    logic [CNT_W-1:0]    thresh_r;
    logic                in_ready_r;
    logic                busy_r;

    logic                hit;
    logic [CNT_W-1:0]    cnt_inc;
    logic                halt_hit;
    logic                halt_now;
    logic                bit_vld;
    logic                clr_hist;
    logic                accept;

    assign cnt_inc  = (det_cnt == '1) ? det_cnt : det_cnt + CNT_W'(1);
    assign halt_hit = hit && (thresh_r != '0) && (cnt_inc == thresh_r);
    // clr on the same cycle as the threshold det cancels the halt.
    assign halt_now = halt_hit && !clr && en;
    // The bit that would enter on the halting edge is dropped with the rest of the byte.
    assign bit_vld  = (state == SHIFT) && en && !halt_now;
    assign clr_hist = !en || ((state == HALT) && clr);
    // A threshold det completed by the last bit of a byte lands while in READY;
    // masking in_ready here keeps the source from handing over a byte that HALT would lose.
    assign in_ready = in_ready_r && !halt_hit;
    assign accept   = in_valid && in_ready;
    assign busy     = busy_r;

    pattern_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (shreg[BYTE_W-1]),
        .bit_vld  (bit_vld),
        .clr_hist (clr_hist),
        .pattern  (pattern_r),
        .len      (len_r),
        .hit      (hit),
        .det      (det)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            pattern_r  <= PAT_W'(DEF_PATTERN);
            len_r      <= LEN_W'(DEF_LEN);
            thresh_r   <= '0;
        end else begin
            if ((state == IDLE) && cfg_we) begin
                pattern_r <= cfg_pattern;
                len_r     <= cfg_len;
                thresh_r  <= cfg_thresh;
            end
            if (!en) begin
                state      <= IDLE;
                in_ready_r <= 1'b0;
                busy_r     <= 1'b0;
                bit_idx    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state      <= READY;
                        in_ready_r <= 1'b1;
                    end
                    READY: begin
                        if (halt_now) begin
                            state      <= HALT;
                            in_ready_r <= 1'b0;
                        end else if (accept) begin
                            shreg      <= in_data;
                            bit_idx    <= '0;
                            state      <= SHIFT;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (halt_now) begin
                            state  <= HALT;
                            busy_r <= 1'b0;
                        end else begin
                            shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                            bit_idx <= bit_idx + IDX_W'(1);
                            if (bit_idx == IDX_W'(BYTE_W - 1)) begin
                                state      <= READY;
                                in_ready_r <= 1'b1;
                                busy_r     <= 1'b0;
                            end
                        end
                    end
                    HALT: begin
                        if (clr) begin
                            state      <= READY;
                            in_ready_r <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            det_cnt <= '0;
            irq     <= 1'b0;
        end else if (clr) begin
            det_cnt <= '0;
            irq     <= 1'b0;
        end else if (hit) begin
            det_cnt <= cnt_inc;
            if (halt_hit) begin
                irq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// tb/tb_seq_det_stream_ctrl.sv - directed self-checking bench for seq_det_stream_ctrl
module tb_seq_det_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_we;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [15:0] cfg_thresh;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        det;
    logic [15:0] det_cnt;
    logic        irq;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef SEQ_DET_NONOVERLAP_EN
    localparam logic [9:1] T2_MASK  = 9'h020;
    localparam int         T2_CNT   = 1;
    localparam logic [9:1] T5_MASK1 = 9'h088;
    localparam int         T5_CNT1  = 2;
    localparam logic [9:1] T5_MASK2 = 9'h088;
    localparam int         T5_CNT2  = 4;
`else
    localparam logic [9:1] T2_MASK  = 9'h120;
    localparam int         T2_CNT   = 2;
    localparam logic [9:1] T5_MASK1 = 9'h0A8;
    localparam int         T5_CNT1  = 3;
    localparam logic [9:1] T5_MASK2 = 9'h0AA;
    localparam int         T5_CNT2  = 7;
`endif

    seq_det_stream_ctrl #(
        .PAT_W (8),
        .CNT_W (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .det         (det),
        .det_cnt     (det_cnt),
        .irq         (irq),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_thresh = 16'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic [15:0] t);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_thresh = t;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    // Hands over one byte and returns det sampled 1..9 cycles after the accept edge.
    task automatic send_byte(input logic [7:0] b, output logic [9:1] dets,
                             output logic rdy_end, output logic busy_mid);
        int n = 0;
        dets = '0; rdy_end = 1'b0; busy_mid = 1'b0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready got %b required 1 (byte %h)", in_ready, b);
        end
        in_valid = 1'b1; in_data = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(posedge clk); #1;
            dets[j] = det;
            if (j == 4) busy_mid = busy;
            if (j == 8) rdy_end = in_ready;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({in_ready, det, irq, busy} !== 4'b0000 || det_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/det/irq/busy got %b cnt %0d required 0000 cnt 0",
                     {in_ready, det, irq, busy}, det_cnt);
        end
    endtask

    task automatic test_single_byte();
        logic [9:1] d; logic r; logic bm;
        do_reset();
        en = 1'b1;
        send_byte(8'hB0, d, r, bm);
        checks++;
        if (d !== 9'h010) begin errors++; $display("FAIL t1_det_mask: got %h required %h", d, 9'h010); end
        checks++;
        if (det_cnt !== 16'd1) begin errors++; $display("FAIL t1_cnt: got %0d required 1", det_cnt); end
        checks++;
        if (r !== 1'b1) begin errors++; $display("FAIL t1_ready_after: got %b required 1", r); end
        checks++;
        if (bm !== 1'b1) begin errors++; $display("FAIL t1_busy_mid: got %b required 1", bm); end
        pulse_clr();
        checks++;
        if (det_cnt !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL t1_clr_ready: cnt %0d rdy %b required cnt 0 rdy 1", det_cnt, in_ready);
        end
    endtask

    task automatic test_overlap();
        logic [9:1] d; logic r; logic bm;
        do_reset();
        en = 1'b1;
        send_byte(8'h5B, d, r, bm);
        checks++;
        if (d !== T2_MASK) begin errors++; $display("FAIL t2_det_mask: got %h required %h", d, T2_MASK); end
        checks++;
        if (det_cnt !== 16'(T2_CNT)) begin errors++; $display("FAIL t2_cnt: got %0d required %0d", det_cnt, T2_CNT); end
    endtask

    task automatic test_cross_byte();
        logic [9:1] d1; logic [9:1] d2; logic r; logic bm;
        do_reset();
        en = 1'b1;
        send_byte(8'h01, d1, r, bm);
        send_byte(8'h60, d2, r, bm);
        checks++;
        if (d1 !== 9'h000 || d2 !== 9'h008) begin
            errors++;
            $display("FAIL t3_det_masks: got %h %h required 000 008", d1, d2);
        end
        checks++;
        if (det_cnt !== 16'd1) begin errors++; $display("FAIL t3_cnt: got %0d required 1", det_cnt); end
    endtask

    task automatic test_threshold_halt();
        logic [9:1] d1; logic [9:1] d2; logic [9:1] d3; logic r; logic bm;
        do_reset();
        cfg_write(8'h0B, 4'd4, 16'd3);
        en = 1'b1;
        send_byte(8'hBB, d1, r, bm);
        send_byte(8'hB0, d2, r, bm);
        checks++;
        if (d1 !== 9'h110 || d2 !== 9'h010) begin
            errors++;
            $display("FAIL t4_det_masks: got %h %h required 110 010", d1, d2);
        end
        checks++;
        if (det_cnt !== 16'd3 || irq !== 1'b1) begin
            errors++;
            $display("FAIL t4_irq_cnt: cnt %0d irq %b required cnt 3 irq 1", det_cnt, irq);
        end
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || r !== 1'b0) begin
            errors++;
            $display("FAIL t4_halt_ready: rdy %b busy %b rdy8 %b required 0 0 0", in_ready, busy, r);
        end
        in_valid = 1'b1; in_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || det_cnt !== 16'd3) begin
            errors++;
            $display("FAIL t4_halt_hold: rdy %b cnt %0d required rdy 0 cnt 3", in_ready, det_cnt);
        end
        in_valid = 1'b0;
        pulse_clr();
        checks++;
        if (det_cnt !== 16'd0 || irq !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL t4_clr_release: cnt %0d irq %b rdy %b required 0 0 1", det_cnt, irq, in_ready);
        end
        send_byte(8'h60, d3, r, bm);
        checks++;
        if (d3 !== 9'h000) begin errors++; $display("FAIL t4_hist_cleared: got %h required 000", d3); end
    endtask

    task automatic test_cfg_len3();
        logic [9:1] d1; logic [9:1] d2; logic r; logic bm;
        do_reset();
        cfg_write(8'h05, 4'd3, 16'd0);
        en = 1'b1;
        send_byte(8'hAA, d1, r, bm);
        checks++;
        if (d1 !== T5_MASK1 || det_cnt !== 16'(T5_CNT1)) begin
            errors++;
            $display("FAIL t5_len3: mask %h cnt %0d required %h %0d", d1, det_cnt, T5_MASK1, T5_CNT1);
        end
        cfg_write(8'h0B, 4'd4, 16'd1);
        send_byte(8'hAA, d2, r, bm);
        checks++;
        if (d2 !== T5_MASK2 || det_cnt !== 16'(T5_CNT2) || irq !== 1'b0) begin
            errors++;
            $display("FAIL t5_cfg_ignored: mask %h cnt %0d irq %b required %h %0d 0",
                     d2, det_cnt, irq, T5_MASK2, T5_CNT2);
        end
    endtask

    task automatic start_partial_b0();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin errors++; $display("FAIL partial_timeout: in_ready got %b required 1", in_ready); end
        in_valid = 1'b1; in_data = 8'hB0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_abort();
        logic [9:1] d; logic r; logic bm; logic seen;
        do_reset();
        en = 1'b1;
        start_partial_b0();
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_abort_idle: rdy %b busy %b required 0 0", in_ready, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | det;
        end
        checks++;
        if (seen !== 1'b0 || det_cnt !== 16'd0) begin
            errors++;
            $display("FAIL t6_abort_nodet: det %b cnt %0d required 0 0", seen, det_cnt);
        end
        en = 1'b1;
        send_byte(8'hC0, d, r, bm);
        checks++;
        if (d !== 9'h000) begin errors++; $display("FAIL t6_abort_hist: got %h required 000", d); end
    endtask

    task automatic test_reset_mid_shift();
        logic [9:1] d; logic r; logic bm;
        do_reset();
        en = 1'b1;
        send_byte(8'hB0, d, r, bm);
        start_partial_b0();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, det, irq, busy} !== 4'b0000 || det_cnt !== 16'd0) begin
            errors++;
            $display("FAIL t6_rst_mid: rdy/det/irq/busy %b cnt %0d required 0000 cnt 0",
                     {in_ready, det, irq, busy}, det_cnt);
        end
        rst = 1'b0;
        send_byte(8'hC0, d, r, bm);
        checks++;
        if (d !== 9'h000 || det_cnt !== 16'd0) begin
            errors++;
            $display("FAIL t6_rst_hist: mask %h cnt %0d required 000 0", d, det_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overlap();
        test_cross_byte();
        test_threshold_halt();
        test_cfg_len3();
        test_abort();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
